// File: rtl/comb_shifter.sv
// comb_shifter: LEN-bit barrel shifter/rotator with one output register stage (latency 1).
// Optional macro COMB_SHIFTER_ARITH_EN adds an 'arith' port for sign-filling logical right shifts.
module comb_shifter #(
    parameter int LEN           = 8,
    parameter int MAX_SHIFT_MAG = 2,
    parameter int wa            = 0,
    localparam int SW           = ($clog2(MAX_SHIFT_MAG + 1) > 1) ? $clog2(MAX_SHIFT_MAG + 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [0:LEN-1] Ip,
    input  logic [SW-1:0] shamt,
`ifdef COMB_SHIFTER_ARITH_EN
    input  logic          arith,
`endif
    input  logic          dir,
    output logic [0:LEN-1] Op,
    output logic          out_valid,
    output logic          clamp
);

    localparam int IW = ($clog2(LEN) > 1) ? $clog2(LEN) : 1;
    localparam logic [SW-1:0] MAX_S = SW'(MAX_SHIFT_MAG);

    generate
        if (MAX_SHIFT_MAG < 1 || MAX_SHIFT_MAG > LEN - 1) begin : g_bad_param
            $error("comb_shifter: MAX_SHIFT_MAG must lie in 1..LEN-1");
        end
    endgenerate

    logic [SW-1:0]  s_eff;
    logic           clamp_next;
    logic           fill;
    logic [0:LEN-1] core;
    int             s_int;
    int             src;

    assign clamp_next = (shamt > MAX_S);
    assign s_eff      = clamp_next ? MAX_S : shamt;
    assign s_int      = int'(s_eff);

`ifdef COMB_SHIFTER_ARITH_EN
    // Only reached for non-wrapping right shifts, so arith is ignored elsewhere.
    assign fill = arith & Ip[0];
`else
    assign fill = 1'b0;
`endif

    // Each output bit picks its source index; out-of-range sources wrap or fill.
    always_comb begin
        core = '0;
        src  = 0;
        for (int i = 0; i < LEN; i++) begin
            if (dir == 1'b0) begin
                src = i + s_int;
                if (src <= LEN - 1)
                    core[i] = Ip[IW'(src)];
                else if (wa != 0)
                    core[i] = Ip[IW'(src - LEN)];
                else
                    core[i] = 1'b0;
            end else begin
                src = i - s_int;
                if (src >= 0)
                    core[i] = Ip[IW'(src)];
                else if (wa != 0)
                    core[i] = Ip[IW'(src + LEN)];
                else
                    core[i] = fill;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Op        <= '0;
            out_valid <= 1'b0;
            clamp     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Op    <= core;
                clamp <= clamp_next;
            end
        end
    end

endmodule

// File: tb/tb_comb_shifter.sv
// tb_comb_shifter: scoreboard bench driving a zero-fill instance and a rotate instance in parallel.
module tb_comb_shifter;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [0:7] Ip;
    logic [1:0] shamt;
    logic       dir;
`ifdef COMB_SHIFTER_ARITH_EN
    logic       arith;
`endif
    logic [0:7] op_log, op_rot;
    logic       ov_log, ov_rot;
    logic       cl_log, cl_rot;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    typedef struct packed {
        logic [0:7] op;
        logic       clamp;
        int         cyc;
    } exp_t;

    exp_t q_log[$];
    exp_t q_rot[$];

    comb_shifter #(.LEN(8), .MAX_SHIFT_MAG(2), .wa(0)) u_log (
        .clk(clk), .rst(rst), .in_valid(in_valid), .Ip(Ip), .shamt(shamt),
`ifdef COMB_SHIFTER_ARITH_EN
        .arith(arith),
`endif
        .dir(dir), .Op(op_log), .out_valid(ov_log), .clamp(cl_log)
    );

    comb_shifter #(.LEN(8), .MAX_SHIFT_MAG(2), .wa(1)) u_rot (
        .clk(clk), .rst(rst), .in_valid(in_valid), .Ip(Ip), .shamt(shamt),
`ifdef COMB_SHIFTER_ARITH_EN
        .arith(arith),
`endif
        .dir(dir), .Op(op_rot), .out_valid(ov_rot), .clamp(cl_rot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Issue one valid word just after a rising edge and record both expected results.
    task automatic applyStimulus(input logic [0:7] ip, input logic [1:0] sh, input logic d,
                                 input logic [0:7] exp_log, input logic [0:7] exp_rot, input logic exp_cl);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        Ip       = ip;
        shamt    = sh;
        dir      = d;
        e.clamp  = exp_cl;
        e.cyc    = cycle;
        e.op     = exp_log;
        q_log.push_back(e);
        e.op     = exp_rot;
        q_rot.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            Ip       = ~Ip;
        end
    endtask

    // Monitor: pop and compare whenever either instance presents a result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ov_log) begin
                if (q_log.size() == 0) begin
                    checkOutput("log_unexpected_valid", 32'(ov_log), 32'd0);
                end else begin
                    e = q_log.pop_front();
                    checkOutput("log_op", 32'(op_log), 32'(e.op));
                    checkOutput("log_clamp", 32'(cl_log), 32'(e.clamp));
                    checkOutput("log_latency", 32'(cycle - e.cyc), 32'd1);
                end
            end
            if (ov_rot) begin
                if (q_rot.size() == 0) begin
                    checkOutput("rot_unexpected_valid", 32'(ov_rot), 32'd0);
                end else begin
                    e = q_rot.pop_front();
                    checkOutput("rot_op", 32'(op_rot), 32'(e.op));
                    checkOutput("rot_clamp", 32'(cl_rot), 32'(e.clamp));
                    checkOutput("rot_latency", 32'(cycle - e.cyc), 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        Ip       = 8'b0000_0000;
        shamt    = 2'd0;
        dir      = 1'b0;
`ifdef COMB_SHIFTER_ARITH_EN
        arith    = 1'b0;
`endif
        #100;
        checkOutput("reset_op", 32'(op_log), 32'd0);
        checkOutput("reset_valid", 32'(ov_log), 32'd0);
        checkOutput("reset_clamp", 32'(cl_rot), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        @(negedge clk);
        checkOutput("idle_op", 32'(op_rot), 32'd0);
        checkOutput("idle_valid", 32'(ov_log), 32'd0);

        applyStimulus(8'b0000_0001, 2'd1, 1'b0, 8'b0000_0010, 8'b0000_0010, 1'b0);
        applyStimulus(8'b0000_0001, 2'd2, 1'b0, 8'b0000_0100, 8'b0000_0100, 1'b0);
        applyStimulus(8'b1000_0001, 2'd2, 1'b1, 8'b0010_0000, 8'b0110_0000, 1'b0);
        applyStimulus(8'b1000_0001, 2'd0, 1'b1, 8'b1000_0001, 8'b1000_0001, 1'b0);
        applyStimulus(8'b1000_0001, 2'd0, 1'b0, 8'b1000_0001, 8'b1000_0001, 1'b0);
        applyStimulus(8'b0000_0001, 2'd3, 1'b0, 8'b0000_0100, 8'b0000_0100, 1'b1);
        applyStimulus(8'b0000_0001, 2'd1, 1'b0, 8'b0000_0010, 8'b0000_0010, 1'b0);
        applyStimulus(8'b1000_0001, 2'd1, 1'b0, 8'b0000_0010, 8'b0000_0011, 1'b0);
        applyStimulus(8'b1011_0101, 2'd1, 1'b1, 8'b0101_1010, 8'b1101_1010, 1'b0);
        applyStimulus(8'b1011_0101, 2'd2, 1'b0, 8'b1101_0100, 8'b1101_0110, 1'b0);
        applyStimulus(8'b1100_0000, 2'd3, 1'b1, 8'b0011_0000, 8'b0011_0000, 1'b1);

        // Hold: no valid while Ip toggles (and goes unknown); outputs must not move.
        idle(1);
        #1 Ip = 'x;
        idle(2);
        @(negedge clk);
        checkOutput("hold_op_log", 32'(op_log), 32'(8'b0011_0000));
        checkOutput("hold_op_rot", 32'(op_rot), 32'(8'b0011_0000));
        checkOutput("hold_clamp", 32'(cl_log), 32'd1);
        checkOutput("hold_valid", 32'(ov_rot), 32'd0);

`ifdef COMB_SHIFTER_ARITH_EN
        #1 arith = 1'b1;
        applyStimulus(8'b1000_0000, 2'd2, 1'b1, 8'b1110_0000, 8'b0010_0000, 1'b0);
        applyStimulus(8'b1000_0001, 2'd1, 1'b0, 8'b0000_0010, 8'b0000_0011, 1'b0);
        idle(1);
        #1 arith = 1'b0;
`endif

        // Mid-stream reset: a captured result is wiped without waiting for an edge.
        applyStimulus(8'b0000_0001, 2'd2, 1'b0, 8'b0000_0100, 8'b0000_0100, 1'b0);
        idle(1);
        #1 rst = 1'b1;
        #1;
        checkOutput("async_rst_op", 32'(op_log), 32'd0);
        checkOutput("async_rst_valid", 32'(ov_rot), 32'd0);
        q_log.delete();
        q_rot.delete();
        @(negedge clk);
        rst = 1'b0;

        // Stimulus in flight when reset hits is discarded.
        applyStimulus(8'b0000_0001, 2'd1, 1'b0, 8'b0000_0010, 8'b0000_0010, 1'b0);
        #2 rst = 1'b1;
        q_log.delete();
        q_rot.delete();
        @(posedge clk);
        #1;
        checkOutput("inflight_valid", 32'(ov_log), 32'd0);
        checkOutput("inflight_op", 32'(op_rot), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(8'b1000_0001, 2'd1, 1'b0, 8'b0000_0010, 8'b0000_0011, 1'b0);
        idle(3);
        @(negedge clk);
        checkOutput("log_queue_drained", 32'(q_log.size()), 32'd0);
        checkOutput("rot_queue_drained", 32'(q_rot.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/comb_shifter.md
Name: comb_shifter

Overview:
- Parameterised barrel shifter/rotator for the datapath: one LEN-bit word in, shifted or rotated by 0..MAX_SHIFT_MAG positions.
- Combinational shift core followed by one output register stage, so latency is one clock.
- Sits between upstream operand logic and downstream consumers using a simple valid-qualified interface with no backpressure.

Parameters:
- LEN, 8, data word width in bits; bit index 0 is the MSB (vectors declared [0:LEN-1]).
- MAX_SHIFT_MAG, 2, largest shift magnitude honoured; elaboration error unless 1 <= MAX_SHIFT_MAG <= LEN-1.
- wa, 0, wrap-around select: 0 = logical shift with zero fill; 1 = rotate.

Ports:
- clk  input  1  sole clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  Ip/shamt/dir qualified this cycle.
- Ip  input  LEN  data word, [0:LEN-1], index 0 = MSB.
- shamt  input  SW  requested shift magnitude; SW = max(1, $clog2(MAX_SHIFT_MAG+1)).
- dir  input  1  0 = left (toward index 0, numeric x2 per step); 1 = right (toward index LEN-1).
- Op  output  LEN  registered shifted/rotated word, [0:LEN-1].
- out_valid  output  1  Op updated by the previous in_valid cycle.
- clamp  output  1  registered; 1 when the captured shamt exceeded MAX_SHIFT_MAG.

Behaviour:
- Reset is asserted asynchronously and released synchronously to clk; while rst=1, Op=0, out_valid=0 and clamp=0, regardless of clk.
- Effective shift s = min(shamt, MAX_SHIFT_MAG); clamp_next = (shamt > MAX_SHIFT_MAG).
- Left, wa=0: Op[i] = Ip[i+s] if i+s <= LEN-1, else 0.
- Right, wa=0: Op[i] = Ip[i-s] if i >= s, else 0.
- Left, wa=1: Op[i] = Ip[(i+s) mod LEN].
- Right, wa=1: Op[i] = Ip[(i-s+LEN) mod LEN].
- s=0: Op = Ip, with either dir and either wa.
- Core is purely combinational; implement it as log2 staged muxes or a case over 0..MAX_SHIFT_MAG.
- Rising clk with in_valid=1: Op, clamp <= core result; out_valid <= 1.
- Rising clk with in_valid=0: Op and clamp hold their previous values; out_valid <= 0.
- Back-to-back in_valid accepted every cycle; throughput one word per clock; no ready signal.
- rst asserted mid-stream: the in-flight result is discarded and outputs go to their reset values immediately.
- First in_valid after reset release produces out_valid exactly one clock later.
- X on Ip with in_valid=0 must not propagate to Op.

Optional Feature:
- Macro COMB_SHIFTER_ARITH_EN.
- Defined: adds input port arith (1 bit).
- When arith=1, wa=0 and dir=1, vacated positions are filled with Ip[0] (sign bit) instead of 0.
- arith is ignored for left shifts and when wa=1.
- Not defined: no arith port; right shifts always zero-fill.

Test Plan:
- Reset: rst=1 for 100 ns with Ip=8'b0000_0000 -> Op=0, out_valid=0, clamp=0; release rst, no in_valid -> outputs stay 0.
- Left shift, wa=0: Ip=8'b0000_0001, dir=0, shamt=1, in_valid=1 -> next clock Op=8'b0000_0010, out_valid=1; shamt=2 -> Op=8'b0000_0100.
- Right shift zero fill, wa=0: Ip=8'b1000_0001, dir=1, shamt=2 -> Op=8'b0010_0000; same with shamt=0 -> Op=8'b1000_0001.
- Clamp: shamt=3 with MAX_SHIFT_MAG=2, Ip=8'b0000_0001, dir=0 -> Op=8'b0000_0100, clamp=1; next valid with shamt=1 -> clamp=0.
- Rotate, wa=1: Ip=8'b1000_0001, dir=0, shamt=1 -> Op=8'b0000_0011; dir=1, shamt=2 -> Op=8'b0110_0000.
- Hold and arithmetic right: in_valid=0 with Ip toggling -> Op unchanged, out_valid=0. With COMB_SHIFTER_ARITH_EN, arith=1, Ip=8'b1000_0000, dir=1, shamt=2 -> Op=8'b1110_0000.
